carry_slice_alu: RTL and testbench

//  Parametrised, slice-serial ALU. One SLICE-bit chunk of a WIDTH-bit operation completes
//  per clock, with the carry rippled through a registered carry between slices.

---
 rtl/carry_slice_alu.sv | 171 +++++++++++++++++
 tb/tb_carry_slice_alu.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carry_slice_alu.sv
// carry_slice_alu: slice-serial ALU with a registered carry between slices.
// One SLICE-bit chunk of a WIDTH-bit operation is processed per clock, so a
// request takes WIDTH/SLICE cycles. Valid/ready handshake on both sides.
// Optional feature macro: CARRY_SLICE_ALU_OVERFLOW_EN (signed-overflow flag).
module carry_slice_alu #(
    parameter int WIDTH = 16,
    parameter int SLICE = 2
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic [2:0]       rx_opcode,
    input  logic             rx_carryflag,
    input  logic [WIDTH-1:0] rx_operand0,
    input  logic [WIDTH-1:0] rx_operand1,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [WIDTH-1:0] tx_result,
    output logic             tx_carryflag,
    output logic             tx_zeroflag,
    output logic             tx_signflag,
    output logic             tx_overflowflag
);

    localparam int NSLICE = (SLICE >= 1) ? (WIDTH / SLICE) : 1;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SBC = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_ORR = 3'd6;
    localparam logic [2:0] OP_EOR = 3'd7;

    if (SLICE < 1 || WIDTH < 2 || (SLICE >= 1 && (WIDTH % SLICE) != 0)) begin : g_param_check
        $error("carry_slice_alu: WIDTH must be >=2 and a multiple of SLICE (SLICE>=1)");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, work_q, work_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, slice_idx;
    int                 base;
    logic [SLICE-1:0]   a_sl, b_sl, b_eff, res_sl;
    logic [SLICE:0]     sum, rol_ext, ror_ext;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge aclk) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs: accept only in IDLE, present only in DONE.
    always_comb begin
        state_d  = state_q;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        case (state_q)
            IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) state_d = BUSY;
            end
            BUSY: begin
                if (cnt_q == LAST_SLICE) state_d = DONE;
            end
            DONE: begin
                tx_valid = 1'b1;
                if (tx_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // One slice of the datapath; ROR walks the slices MSB-first so its carry moves downward.
    always_comb begin
        slice_idx = (op_q == OP_ROR) ? (LAST_SLICE - cnt_q) : cnt_q;
        base      = int'(slice_idx) * SLICE;
        a_sl      = a_q[base +: SLICE];
        b_sl      = b_q[base +: SLICE];
        b_eff     = (op_q == OP_SBC) ? ~b_sl : b_sl;
        sum       = {1'b0, a_sl} + {1'b0, b_eff} + (SLICE+1)'(carry_q);
        rol_ext   = {a_sl, carry_q};
        ror_ext   = {carry_q, a_sl};
        res_sl    = a_sl;
        carry_d   = carry_q;
        case (op_q)
            OP_NOP: begin res_sl = a_sl;                 carry_d = carry_q;        end
            OP_ADC,
            OP_SBC: begin res_sl = sum[SLICE-1:0];       carry_d = sum[SLICE];     end
            OP_ROL: begin res_sl = rol_ext[SLICE-1:0];   carry_d = rol_ext[SLICE]; end
            OP_ROR: begin res_sl = ror_ext[SLICE:1];     carry_d = ror_ext[0];     end
            OP_AND: begin res_sl = a_sl & b_sl;          carry_d = carry_q;        end
            OP_ORR: begin res_sl = a_sl | b_sl;          carry_d = carry_q;        end
            OP_EOR: begin res_sl = a_sl ^ b_sl;          carry_d = carry_q;        end
            default: begin res_sl = a_sl;                carry_d = carry_q;        end
        endcase
        work_d = work_q;
        work_d[base +: SLICE] = res_sl;
    end

    // Operand latch, slice sequencing, and result/flag capture on the last slice only.
    always_ff @(posedge aclk) begin
        if (areset) begin
            op_q         <= OP_NOP;
            a_q          <= '0;
            b_q          <= '0;
            carry_q      <= 1'b0;
            cnt_q        <= '0;
            work_q       <= '0;
            tx_result    <= '0;
            tx_carryflag <= 1'b0;
            tx_zeroflag  <= 1'b0;
            tx_signflag  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        op_q    <= rx_opcode;
                        a_q     <= rx_operand0;
                        b_q     <= rx_operand1;
                        carry_q <= rx_carryflag;
                        cnt_q   <= '0;
                        work_q  <= '0;
                    end
                end
                BUSY: begin
                    work_q  <= work_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_SLICE) begin
                        tx_result    <= work_d;
                        tx_carryflag <= carry_d;
                        tx_zeroflag  <= (work_d == '0);
                        tx_signflag  <= work_d[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CARRY_SLICE_ALU_OVERFLOW_EN
    logic b_top;
    logic ovf_d;

    // Signed overflow from the operand signs and the sign of the finished result.
    always_comb begin
        b_top = (op_q == OP_SBC) ? ~b_q[WIDTH-1] : b_q[WIDTH-1];
        ovf_d = ((op_q == OP_ADC) || (op_q == OP_SBC)) &&
                (a_q[WIDTH-1] == b_top) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
    end

    // Overflow flag captured alongside the other flags when DONE is entered.
    always_ff @(posedge aclk) begin
        if (areset)
            tx_overflowflag <= 1'b0;
        else if (state_q == BUSY && cnt_q == LAST_SLICE)
            tx_overflowflag <= ovf_d;
    end
`else
    assign tx_overflowflag = 1'b0;
`endif

endmodule

// File: tb/tb_carry_slice_alu.sv
// tb_carry_slice_alu: drives an 8-bit/2-bit-slice and a 16-bit/4-bit-slice
// instance, predicting results with a whole-word model and a scoreboard queue.
module tb_carry_slice_alu;

    localparam int LAT = 4;

    typedef struct {
        logic [15:0] result;
        logic        c;
        logic        z;
        logic        n;
        logic        v;
    } exp_t;

    logic        aclk = 1'b0;
    logic        areset;
    logic        rx_valid;
    logic        sel16;
    logic [2:0]  rx_opcode;
    logic        rx_carryflag;
    logic [15:0] rx_a, rx_b;
    logic        tx_ready;

    logic        rx_valid8, rx_valid16;
    logic        rdy8, val8, c8, z8, n8, v8;
    logic [7:0]  res8;
    logic        rdy16, val16, c16, z16, n16, v16;
    logic [15:0] res16;

    logic        obs_rdy, obs_val, obs_c, obs_z, obs_n, obs_v;
    logic [15:0] obs_res;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 aclk = ~aclk;

    assign rx_valid8  = rx_valid & ~sel16;
    assign rx_valid16 = rx_valid & sel16;

    carry_slice_alu #(.WIDTH(8), .SLICE(2)) u_alu8 (
        .aclk(aclk), .areset(areset),
        .rx_valid(rx_valid8), .rx_ready(rdy8), .rx_opcode(rx_opcode),
        .rx_carryflag(rx_carryflag), .rx_operand0(rx_a[7:0]), .rx_operand1(rx_b[7:0]),
        .tx_valid(val8), .tx_ready(tx_ready), .tx_result(res8),
        .tx_carryflag(c8), .tx_zeroflag(z8), .tx_signflag(n8), .tx_overflowflag(v8)
    );

    carry_slice_alu #(.WIDTH(16), .SLICE(4)) u_alu16 (
        .aclk(aclk), .areset(areset),
        .rx_valid(rx_valid16), .rx_ready(rdy16), .rx_opcode(rx_opcode),
        .rx_carryflag(rx_carryflag), .rx_operand0(rx_a), .rx_operand1(rx_b),
        .tx_valid(val16), .tx_ready(tx_ready), .tx_result(res16),
        .tx_carryflag(c16), .tx_zeroflag(z16), .tx_signflag(n16), .tx_overflowflag(v16)
    );

    // Present whichever instance the current test is using.
    always_comb begin
        if (sel16) begin
            obs_rdy = rdy16; obs_val = val16; obs_res = res16;
            obs_c = c16; obs_z = z16; obs_n = n16; obs_v = v16;
        end else begin
            obs_rdy = rdy8; obs_val = val8; obs_res = {8'h00, res8};
            obs_c = c8; obs_z = z8; obs_n = n8; obs_v = v8;
        end
    end

    // Whole-word reference model for width w.
    function automatic exp_t model(input int w, input logic [2:0] op,
                                   input logic [15:0] a_in, input logic [15:0] b_in,
                                   input logic c);
        exp_t        e;
        logic [31:0] mask, a, b, bp, s, r;
        logic        co, v;
        mask = (32'd1 << w) - 32'd1;
        a  = {16'h0000, a_in} & mask;
        b  = {16'h0000, b_in} & mask;
        bp = b;
        s  = 32'd0;
        r  = a;
        co = c;
        case (op)
            3'd1: begin s = a + b + {31'd0, c};  r = s & mask; co = s[w]; end
            3'd2: begin bp = ~b & mask; s = a + bp + {31'd0, c}; r = s & mask; co = s[w]; end
            3'd3: begin r = ((a << 1) | {31'd0, c}) & mask; co = a[w-1]; end
            3'd4: begin r = ({31'd0, c} << (w-1)) | (a >> 1); co = a[0]; end
            3'd5: r = a & b;
            3'd6: r = a | b;
            3'd7: r = a ^ b;
            default: begin r = a; co = c; end
        endcase
        v = 1'b0;
`ifdef CARRY_SLICE_ALU_OVERFLOW_EN
        if (op == 3'd1 || op == 3'd2)
            v = (a[w-1] == bp[w-1]) && (r[w-1] != a[w-1]);
`endif
        e.result = r[15:0];
        e.c = co;
        e.z = (r == 32'd0);
        e.n = r[w-1];
        e.v = v;
        return e;
    endfunction

    // Scoreboard: compare whenever a result is handed over (valid && ready).
    always @(negedge aclk) begin
        exp_t e;
        if (areset === 1'b0 && obs_val === 1'b1 && tx_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL scoreboard_empty: got unexpected result %h, required none", obs_res);
            end else begin
                e = exp_q.pop_front();
                if (obs_res !== e.result) begin
                    errors++;
                    $display("[TB] FAIL sb_result: got %h required %h", obs_res, e.result);
                end
                checks++;
                if (obs_c !== e.c) begin
                    errors++;
                    $display("[TB] FAIL sb_carry: got %b required %b", obs_c, e.c);
                end
                checks++;
                if (obs_z !== e.z) begin
                    errors++;
                    $display("[TB] FAIL sb_zero: got %b required %b", obs_z, e.z);
                end
                checks++;
                if (obs_n !== e.n) begin
                    errors++;
                    $display("[TB] FAIL sb_sign: got %b required %b", obs_n, e.n);
                end
                checks++;
                if (obs_v !== e.v) begin
                    errors++;
                    $display("[TB] FAIL sb_overflow: got %b required %b", obs_v, e.v);
                end
            end
        end
    end

    // Drive one request (starting at a negedge) and push its prediction.
    task automatic issue(input logic wide, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic c);
        int n;
        n = 0;
        sel16 = wide;
        while (obs_rdy !== 1'b1 && n < 50) begin
            @(posedge aclk); @(negedge aclk); n++;
        end
        rx_opcode    = op;
        rx_a         = a;
        rx_b         = b;
        rx_carryflag = c;
        rx_valid     = 1'b1;
        exp_q.push_back(model(wide ? 16 : 8, op, a, b, c));
        @(posedge aclk);
        @(negedge aclk);
        rx_valid = 1'b0;
    endtask

    // Count edges after the accept edge until tx_valid appears (bounded).
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (obs_val !== 1'b1 && cyc < 40) begin
            @(posedge aclk); cyc++; @(negedge aclk);
        end
    endtask

    task automatic test_reset;
        areset = 1'b1; rx_valid = 1'b0; tx_ready = 1'b1; sel16 = 1'b0;
        rx_opcode = 3'd0; rx_a = 16'h0; rx_b = 16'h0; rx_carryflag = 1'b0;
        repeat (2) begin @(posedge aclk); @(negedge aclk); end
        checks++; if (rdy8 !== 1'b1)   begin errors++; $display("[TB] FAIL reset_rx_ready: got %b required 1", rdy8); end
        checks++; if (val8 !== 1'b0)   begin errors++; $display("[TB] FAIL reset_tx_valid: got %b required 0", val8); end
        checks++; if (res8 !== 8'h00)  begin errors++; $display("[TB] FAIL reset_result: got %h required 00", res8); end
        checks++; if (c8 !== 1'b0)     begin errors++; $display("[TB] FAIL reset_carry: got %b required 0", c8); end
        checks++; if (z8 !== 1'b0)     begin errors++; $display("[TB] FAIL reset_zero: got %b required 0", z8); end
        checks++; if (n8 !== 1'b0)     begin errors++; $display("[TB] FAIL reset_sign: got %b required 0", n8); end
        checks++; if (v8 !== 1'b0)     begin errors++; $display("[TB] FAIL reset_overflow: got %b required 0", v8); end
        checks++; if (val16 !== 1'b0 || rdy16 !== 1'b1 || res16 !== 16'h0)
            begin errors++; $display("[TB] FAIL reset_w16: got valid=%b ready=%b result=%h required 0/1/0000", val16, rdy16, res16); end
        areset = 1'b0;
        @(posedge aclk); @(negedge aclk);
    endtask

    // Single request with latency check, then hand the result over.
    task automatic run_one(input string name, input logic wide, input logic [2:0] op,
                           input logic [15:0] a, input logic [15:0] b, input logic c);
        int cyc;
        issue(wide, op, a, b, c);
        wait_valid(cyc);
        checks++;
        if (cyc != LAT) begin
            errors++;
            $display("[TB] FAIL %s_latency: got %0d cycles required %0d", name, cyc, LAT);
        end
        @(posedge aclk); @(negedge aclk);
    endtask

    task automatic test_adc;
        run_one("adc8", 1'b0, 3'd1, 16'h00FF, 16'h0001, 1'b0);
    endtask

    task automatic test_sbc;
        run_one("sbc8", 1'b0, 3'd2, 16'h0080, 16'h0001, 1'b1);
    endtask

    task automatic test_rotate;
        run_one("rol8", 1'b0, 3'd3, 16'h0081, 16'h0000, 1'b0);
        run_one("ror8", 1'b0, 3'd4, 16'h0001, 16'h0000, 1'b1);
    endtask

    task automatic test_eor16;
        run_one("eor16", 1'b1, 3'd7, 16'hA5A5, 16'hA5A5, 1'b1);
    endtask

    task automatic test_hold;
        int   cyc;
        exp_t e;
        e = model(8, 3'd1, 16'h007F, 16'h0001, 1'b0);
        tx_ready = 1'b0;
        issue(1'b0, 3'd1, 16'h007F, 16'h0001, 1'b0);
        wait_valid(cyc);
        checks++;
        if (cyc != LAT) begin errors++; $display("[TB] FAIL hold_latency: got %0d required %0d", cyc, LAT); end
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk); @(negedge aclk);
            checks++;
            if (obs_val !== 1'b1 || obs_rdy !== 1'b0 || obs_res !== e.result ||
                obs_c !== e.c || obs_n !== e.n || obs_v !== e.v)
            begin
                errors++;
                $display("[TB] FAIL hold_stable: cycle %0d got valid=%b ready=%b result=%h c=%b n=%b v=%b required 1/0/%h/%b/%b/%b",
                         i, obs_val, obs_rdy, obs_res, obs_c, obs_n, obs_v, e.result, e.c, e.n, e.v);
            end
        end
        @(posedge aclk);
        #2 tx_ready = 1'b1;
        @(negedge aclk);
        @(posedge aclk); @(negedge aclk);
        checks++;
        if (obs_val !== 1'b0 || obs_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_release: got valid=%b ready=%b required 0/1", obs_val, obs_rdy);
        end
        checks++;
        if (obs_res !== e.result) begin
            errors++;
            $display("[TB] FAIL idle_retain: got %h required %h", obs_res, e.result);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        issue(1'b0, 3'd5, 16'h00F3, 16'h003C, 1'b1);
        checks++;
        if (obs_rdy !== 1'b0) begin errors++; $display("[TB] FAIL busy_rx_ready: got %b required 0", obs_rdy); end
        wait_valid(cyc);
        checks++;
        if (cyc != LAT) begin errors++; $display("[TB] FAIL b2b_latency: got %0d required %0d", cyc, LAT); end
        @(posedge aclk); @(negedge aclk);
        checks++;
        if (obs_rdy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rx_ready: got %b required 1", obs_rdy); end
        run_one("orr8", 1'b0, 3'd6, 16'h000F, 16'h00F0, 1'b0);
        run_one("nop8", 1'b0, 3'd0, 16'h005A, 16'h0000, 1'b1);
    endtask

    task automatic test_reset_midop;
        sel16 = 1'b0;
        rx_opcode = 3'd1; rx_a = 16'h003C; rx_b = 16'h0055; rx_carryflag = 1'b1;
        rx_valid = 1'b1;
        @(posedge aclk); @(negedge aclk);
        rx_valid = 1'b0;
        repeat (2) begin @(posedge aclk); @(negedge aclk); end
        areset = 1'b1;
        @(posedge aclk); @(negedge aclk);
        checks++;
        if (obs_rdy !== 1'b1 || obs_val !== 1'b0 || obs_res !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL midop_reset: got ready=%b valid=%b result=%h required 1/0/0000", obs_rdy, obs_val, obs_res);
        end
        areset = 1'b0;
        repeat (4) begin @(posedge aclk); @(negedge aclk); end
        checks++;
        if (obs_val !== 1'b0) begin errors++; $display("[TB] FAIL midop_discard: got valid=%b required 0", obs_val); end
        run_one("post_reset_adc", 1'b0, 3'd1, 16'h003C, 16'h0055, 1'b1);
    endtask

    task automatic test_random;
        logic        wide;
        logic [2:0]  op;
        logic [15:0] a, b;
        logic        c;
        for (int i = 0; i < 12; i++) begin
            wide = 1'($urandom_range(0, 1));
            op   = 3'($urandom_range(0, 7));
            a    = 16'($urandom);
            b    = 16'($urandom);
            c    = 1'($urandom_range(0, 1));
            run_one("random", wide, op, a, b, c);
        end
    endtask

    initial begin
        sel16 = 1'b0; rx_valid = 1'b0; tx_ready = 1'b1; areset = 1'b1;
        rx_opcode = 3'd0; rx_a = 16'h0; rx_b = 16'h0; rx_carryflag = 1'b0;
        @(negedge aclk);
        test_reset;
        test_adc;
        test_sbc;
        test_rotate;
        test_eor16;
        test_hold;
        test_back_to_back;
        test_reset_midop;
        test_random;
        repeat (2) begin @(posedge aclk); @(negedge aclk); end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
